// File: rtl/step_clock_ctrl.sv
// rtl/step_clock_ctrl.sv - operator-controlled processor clock: free-run, single-step, halt, cycle count
// Optional feature macro: STEP_DEBOUNCE_EN (defined = step button debouncer built in)
module step_clock_ctrl #(
    parameter int DIV       = 25_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_run,
    input  logic             btn_step,
    input  logic             halt,
    output logic             out_clk,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int PH_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    logic run_s1_q, run_s2_q, btn_s1_q, btn_s2_q;
    logic btn_db, btn_db_prev_q, step_req_q, step_req_d;

    state_t           state_q, state_d;
    logic             out_clk_q, out_clk_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            run_s1_q <= 1'b0;
            run_s2_q <= 1'b0;
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
        end else begin
            run_s1_q <= sw_run;
            run_s2_q <= run_s1_q;
            btn_s1_q <= btn_step;
            btn_s2_q <= btn_s1_q;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;

    // Any cycle where the synced button agrees with the accepted level restarts the count.
    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (btn_s2_q != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    assign btn_db = btn_db_q;
`else
    assign btn_db = btn_s2_q;
`endif

    assign step_req_d = btn_db & ~btn_db_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_prev_q <= 1'b0;
            step_req_q    <= 1'b0;
        end else begin
            btn_db_prev_q <= btn_db;
            step_req_q    <= step_req_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_clk_d = out_clk_q;
        tick_d    = 1'b0;
        ph_cnt_d  = ph_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                out_clk_d = 1'b0;
                ph_cnt_d  = '0;
                if (run_s2_q && !halt) begin
                    state_d   = RUN;
                    out_clk_d = 1'b1;
                    tick_d    = 1'b1;
                end else if (step_req_q && !halt) begin
                    state_d   = STEP;
                    out_clk_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN, STEP: begin
                if (ph_cnt_q == PH_LAST) begin
                    ph_cnt_d = '0;
                    if (out_clk_q) begin
                        out_clk_d = 1'b0;
                    end else if (state_q == RUN && run_s2_q && !halt) begin
                        // Back-to-back periods: no idle gap between low and next high.
                        out_clk_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        out_clk_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                out_clk_d = 1'b0;
                ph_cnt_d  = '0;
            end
        endcase
        running_d     = (state_d != IDLE);
        cycle_count_d = cycle_count_q;
        if (tick_d && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            out_clk_q     <= 1'b0;
            tick_q        <= 1'b0;
            running_q     <= 1'b0;
            ph_cnt_q      <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            out_clk_q     <= out_clk_d;
            tick_q        <= tick_d;
            running_q     <= running_d;
            ph_cnt_q      <= ph_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign out_clk     = out_clk_q;
    assign tick        = tick_q;
    assign running     = running_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: doc/step_clock_ctrl.md
# step_clock_ctrl

Processor clock generator for the single-cycle core, feeding `out_clk` to the program counter, register file, data memory and display counters. It replaces a free-running divider with an operator-controlled clock: free-run at a divided rate from a switch, or single-step one processor cycle per debounced button press. It also stops on a core `halt` flag and counts executed processor cycles.

## Interface
- `DIV`, 25_000_000: `out_clk` high-phase and low-phase length in `clk` cycles; min 1.
- `DB_CYCLES`, 1_000_000: consecutive stable `clk` cycles required to accept a new button level; min 1.
- `CNT_W`, 16: `cycle_count` width.

- `clk`  in  1  board clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_run`  in  1  raw run switch, asynchronous; 1 = free-run.
- `btn_step`  in  1  raw step button, asynchronous, active-high, bouncy.
- `halt`  in  1  core halt request, synchronous to `clk`.
- `out_clk`  out  1  registered processor clock.
- `tick`  out  1  one-`clk` pulse in the cycle `out_clk` goes 0→1.
- `running`  out  1  1 while in RUN or STEP.
- `cycle_count`  out  CNT_W  number of `tick`s since reset; saturates at all-ones.

## Operation
- `sw_run` and `btn_step` each pass through a 2-flop synchronizer.
- Debouncer: the accepted level `btn_db` changes only after the synchronized button differs from it for `DB_CYCLES` consecutive cycles. Any mismatch gap clears the counter. `step_req` is a 1-cycle pulse on `btn_db` 0→1.
- Phase counter `ph_cnt` counts 0..DIV-1 and clears on every phase boundary.
- FSM states: IDLE, RUN, STEP.
  - IDLE: `out_clk`=0.
    - Synced `sw_run`=1 and `halt`=0 → RUN. Otherwise `step_req` and `halt`=0 → STEP. Run has priority over step.
    - On the transition cycle, `out_clk`←1, `tick`←1, `ph_cnt`←0.
  - RUN/STEP, high phase: at `ph_cnt`=DIV-1, `out_clk`←0.
  - RUN, end of low phase (`ph_cnt`=DIV-1 with `out_clk`=0):
    - If `sw_run`=1 and `halt`=0: `out_clk`←1 and `tick`←1 (next period).
    - Otherwise go to IDLE.
  - STEP, end of low phase: go to IDLE. Exactly one period per step.
- A period, once started, always completes in full: high DIV cycles, then low DIV cycles. `sw_run` falling or `halt` rising mid-period takes effect only at the period end.
- `step_req` is ignored outside IDLE. It is not queued.
- `cycle_count` increments on each `tick` and holds at 2^CNT_W−1.

## Timing
- Reset values: `out_clk`=0, `tick`=0, `running`=0, `cycle_count`=0, state IDLE, `btn_db`=0, all counters 0, synchronizer flops 0.
- `rst` mid-period forces all reset values on the next edge. `out_clk` may be truncated; this is acceptable because the core is reset simultaneously.
- `sw_run` edge to first `tick`: 3 `clk` cycles (2 sync + 1 FSM).
- Button press to `tick`: 2 sync + `DB_CYCLES` + 1 (edge detect) + 1 (FSM) cycles.
- `out_clk` period in RUN: exactly 2·DIV, duty 50%, with no gap between periods.
- `running` is registered and updates in the same edge as the state.
- `halt` is sampled only in IDLE and at the end of the low phase.

## Configuration
- `STEP_DEBOUNCE_EN`:
  - Defined: the debouncer is built as described.
  - Undefined: `btn_db` is the synchronized button directly, `DB_CYCLES` is unused, and press-to-`tick` latency is 4 cycles.

## Test plan
All scenarios use DIV=2, DB_CYCLES=4, CNT_W=4, and `STEP_DEBOUNCE_EN` defined unless noted.
- Reset: hold `rst` 3 cycles with `sw_run`=1 → `out_clk`=0, `tick`=0, `running`=0, `cycle_count`=0 throughout.
- Single step: `btn_step` high for 12 cycles → one `tick` 8 cycles after press; `out_clk` high 2 cycles, then low 2 cycles; back to IDLE; `cycle_count`=1.
- Bounce: `btn_step` toggles every cycle for 20 cycles, then stays 0 → no `tick`, `cycle_count`=0. Without the macro the same stimulus gives ≥1 tick.
- Run and stop: `sw_run`=1 → ticks every 4 cycles. Drop `sw_run` one cycle into a high phase → that period completes (high 2, low 2), `out_clk` ends at 0, no further tick.
- Halt: raise `halt` during RUN → current period completes, state goes to IDLE. A button press while `halt`=1 gives no tick.
- Saturation and reset: run 20 periods → `cycle_count` sticks at 15. Assert `rst` while `out_clk`=1 → next cycle `out_clk`=0 and `cycle_count`=0.
